// File: rtl/pcm_pkg.sv
// Shared definitions for the PCM byte packer: FSM states, sync pattern and frame geometry.
package pcm_pkg;

    localparam int unsigned BYTES_PER_FRAME = 3;
    localparam logic [23:0] PCM_SYNC_WORD   = 24'hAAFF00;

    typedef enum logic [1:0] {
        StIdle,
        StByte0,
        StByte1,
        StByte2
    } pcm_state_e;

    // Select byte idx of a frame word, LSB first.
    function automatic logic [7:0] frame_byte(input logic [23:0] word, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < BYTES_PER_FRAME; i++) begin
            if (idx == 2'(i)) begin
                b = word[8*i +: 8];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer plus a third flop for rising-edge detection of an asynchronous level.
// An input already high when reset releases is not reported until it has been seen low.
module pulse_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic ff1, ff2, ff3;
    logic vld1, vld2;
    logic armed;

    // Synchronizer chain; armed only once ff2 has carried a real low sample after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff1   <= 1'b0;
            ff2   <= 1'b0;
            ff3   <= 1'b0;
            vld1  <= 1'b0;
            vld2  <= 1'b0;
            armed <= 1'b0;
        end else begin
            ff1  <= async_i;
            ff2  <= ff1;
            ff3  <= ff2;
            vld1 <= 1'b1;
            vld2 <= vld1;
            if (vld2 && !ff2) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise_o = ff2 & ~ff3 & armed;

endmodule

// File: rtl/pcm_byte_packer.sv
// Packs 24-bit PCM samples into 3-byte frames (LSB first) for a downstream byte FIFO.
// One frame in flight plus a one-entry pending slot; further samples are dropped and counted.
// Build option PCM_PACKER_SYNC_EN: insert a SYNC_WORD frame after every SYNC_PERIOD data frames.
module pcm_byte_packer
    import pcm_pkg::*;
#(
    parameter int unsigned SYNC_PERIOD = 127,
    parameter logic [23:0] SYNC_WORD   = PCM_SYNC_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_done,
    input  logic [23:0] sample_data,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic [15:0] drop_count,
    output logic        busy
);

    if (SYNC_PERIOD < 2 || SYNC_PERIOD > 1023) begin : g_bad_period
        $error("SYNC_PERIOD must be in 2..1023");
    end

    logic        rise;
    pcm_state_e  state;
    logic [23:0] cap_q, pend_q;
    logic        cap_vld_q, pend_vld_q;
    logic        sync_q, sync_due;
    logic [23:0] word;
    logic        frame_done, cap_free, next_avail;

    pulse_sync u_pulse_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (sample_done),
        .rise_o  (rise)
    );

    // cap_q holds the data frame in flight or about to start; a sync frame leaves it untouched.
    assign word       = sync_q ? SYNC_WORD : cap_q;
    assign frame_done = (state == StByte2) && fifo_wr_en;
    assign cap_free   = ~sync_q | ~cap_vld_q;
    assign next_avail = cap_free ? (pend_vld_q | rise) : 1'b1;
    assign busy       = (state != StIdle) | pend_vld_q;

`ifdef PCM_PACKER_SYNC_EN
    logic [9:0] frame_cnt_q;

    // Count completed data frames; reaching SYNC_PERIOD schedules one sync frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            sync_q      <= 1'b0;
        end else if (frame_done) begin
            if (sync_q) begin
                sync_q <= 1'b0;
            end else if (sync_due) begin
                frame_cnt_q <= '0;
                sync_q      <= 1'b1;
            end else begin
                frame_cnt_q <= frame_cnt_q + 10'd1;
            end
        end
    end

    assign sync_due = ~sync_q & (frame_cnt_q == 10'(SYNC_PERIOD - 1));
`else
    assign sync_q   = 1'b0;
    assign sync_due = 1'b0;
`endif

    // Capture / pending slot management and drop counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q      <= '0;
            cap_vld_q  <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            drop_count <= '0;
        end else if (frame_done && cap_free) begin
            // Frame boundary: pending advances, a simultaneous edge is never dropped.
            if (pend_vld_q) begin
                cap_q      <= pend_q;
                cap_vld_q  <= 1'b1;
                pend_vld_q <= rise;
                if (rise) begin
                    pend_q <= sample_data;
                end
            end else if (rise) begin
                cap_q     <= sample_data;
                cap_vld_q <= 1'b1;
            end else begin
                cap_vld_q <= 1'b0;
            end
        end else if (rise) begin
            if (state == StIdle && !cap_vld_q) begin
                cap_q     <= sample_data;
                cap_vld_q <= 1'b1;
            end else if (!pend_vld_q) begin
                pend_q     <= sample_data;
                pend_vld_q <= 1'b1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Byte FSM: a state advances only on a cycle that actually wrote its byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= StIdle;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= 8'h00;
        end else begin
            fifo_wr_en <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cap_vld_q) begin
                        state        <= StByte0;
                        fifo_wr_en   <= ~fifo_full;
                        fifo_wr_data <= frame_byte(word, 2'd0);
                    end
                end
                StByte0: begin
                    fifo_wr_en <= ~fifo_full;
                    if (fifo_wr_en) begin
                        state        <= StByte1;
                        fifo_wr_data <= frame_byte(word, 2'd1);
                    end else begin
                        fifo_wr_data <= frame_byte(word, 2'd0);
                    end
                end
                StByte1: begin
                    fifo_wr_en <= ~fifo_full;
                    if (fifo_wr_en) begin
                        state        <= StByte2;
                        fifo_wr_data <= frame_byte(word, 2'd2);
                    end else begin
                        fifo_wr_data <= frame_byte(word, 2'd1);
                    end
                end
                StByte2: begin
                    if (fifo_wr_en) begin
                        // Next frame starts with a one-cycle gap while word settles.
                        state <= (sync_due || next_avail) ? StByte0 : StIdle;
                    end else begin
                        fifo_wr_en   <= ~fifo_full;
                        fifo_wr_data <= frame_byte(word, 2'd2);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_byte_packer.sv
// Directed bench for pcm_byte_packer; expectations follow PCM_PACKER_SYNC_EN when defined.
module tb_pcm_byte_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_done = 1'b0;
    logic [23:0] sample_data = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [15:0] drop_count;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int t0 = 0;
    logic [7:0] wq[$];
    int         cq[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    pcm_byte_packer #(
        .SYNC_PERIOD (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_done  (sample_done),
        .sample_data  (sample_data),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    // Record every written byte with its cycle number; flag writes issued against a full FIFO.
    always @(posedge clk) begin : mon
        logic full_at_edge;
        full_at_edge = fifo_full;
        #1;
        cyc++;
        if (fifo_wr_en) begin
            wq.push_back(fifo_wr_data);
            cq.push_back(cyc);
            if (full_at_edge) viol++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        logic [7:0] g;
        check_eq({tag, "_len"}, 32'(wq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < wq.size()) ? wq[i] : 8'hxx;
            check_eq($sformatf("%s_b%0d", tag, i), 32'(g), 32'(exp[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sample_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse(input logic [23:0] d, input int hi, input int lo);
        @(negedge clk);
        sample_data = d;
        sample_done = 1'b1;
        repeat (hi) @(negedge clk);
        sample_done = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic clear_log();
        wq.delete();
        cq.delete();
        exp_q.delete();
        viol = 0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check_eq("rst_wr_data", 32'(fifo_wr_data), 32'h00);
        check_eq("rst_drop", 32'(drop_count), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single sample, latency
        clear_log();
        @(negedge clk);
        sample_data = 24'h123456;
        sample_done = 1'b1;
        t0 = cyc + 1;
        repeat (4) @(negedge clk);
        sample_done = 1'b0;
        repeat (8) @(negedge clk);
        exp_q = '{8'h56, 8'h34, 8'h12};
        check_stream("single", exp_q);
        check_eq("single_lat0", 32'(cq.size() > 0 ? cq[0] : -1), 32'(t0 + 3));
        check_eq("single_lat1", 32'(cq.size() > 1 ? cq[1] : -1), 32'(t0 + 4));
        check_eq("single_lat2", 32'(cq.size() > 2 ? cq[2] : -1), 32'(t0 + 5));
        check_eq("single_busy", 32'(busy), 32'h0);

        // Backpressure after byte0
        do_reset();
        clear_log();
        @(negedge clk);
        sample_data = 24'hABCDEF;
        sample_done = 1'b1;
        t0 = cyc + 1;
        repeat (4) @(negedge clk);
        fifo_full = 1'b1;
        sample_done = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("bp_busy_full", 32'(busy), 32'h1);
        fifo_full = 1'b0;
        repeat (6) @(negedge clk);
        exp_q = '{8'hEF, 8'hCD, 8'hAB};
        check_stream("bp", exp_q);
        check_eq("bp_t0", 32'(cq.size() > 0 ? cq[0] : -1), 32'(t0 + 3));
        check_eq("bp_t1", 32'(cq.size() > 1 ? cq[1] : -1), 32'(t0 + 14));
        check_eq("bp_t2", 32'(cq.size() > 2 ? cq[2] : -1), 32'(t0 + 15));
        check_eq("bp_viol", 32'(viol), 32'h0);

        // Overflow: third sample dropped while full
        do_reset();
        clear_log();
        fifo_full = 1'b1;
        pulse(24'hA1A2A3, 4, 4);
        pulse(24'hB1B2B3, 4, 4);
        pulse(24'hC1C2C3, 4, 4);
        check_eq("ovf_drop", 32'(drop_count), 32'h1);
        check_eq("ovf_busy", 32'(busy), 32'h1);
        check_eq("ovf_nowrite", 32'(wq.size()), 32'h0);
        fifo_full = 1'b0;
        repeat (20) @(negedge clk);
        exp_q = '{8'hA3, 8'hA2, 8'hA1, 8'hB3, 8'hB2, 8'hB1};
        check_stream("ovf", exp_q);
        check_eq("ovf_drop_end", 32'(drop_count), 32'h1);
        check_eq("ovf_viol", 32'(viol), 32'h0);

        // Nine samples: sync frames only with the build option
        do_reset();
        clear_log();
        for (int i = 1; i <= 9; i++) begin
            pulse({8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)}, 4, 4);
        end
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h20 + i));
            exp_q.push_back(8'(8'h30 + i));
`ifdef PCM_PACKER_SYNC_EN
            if (i == 4 || i == 8) begin
                exp_q.push_back(8'h00);
                exp_q.push_back(8'hFF);
                exp_q.push_back(8'hAA);
            end
`endif
        end
        check_stream("sync", exp_q);
        check_eq("sync_drop", 32'(drop_count), 32'h0);

        // Reset after byte1 abandons the frame
        do_reset();
        clear_log();
        @(negedge clk);
        sample_data = 24'h654321;
        sample_done = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        sample_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        pulse(24'h000102, 4, 8);
        exp_q = '{8'h21, 8'h43, 8'h02, 8'h01, 8'h00};
        check_stream("midrst", exp_q);
        check_eq("midrst_drop", 32'(drop_count), 32'h0);

        // Level already high at reset release is not an edge
        @(negedge clk);
        rst_n = 1'b0;
        sample_data = 24'h777777;
        sample_done = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("hi_rel_nowrite", 32'(wq.size()), 32'h0);
        check_eq("hi_rel_busy", 32'(busy), 32'h0);
        sample_done = 1'b0;
        repeat (4) @(negedge clk);
        pulse(24'h0A0B0C, 4, 8);
        exp_q = '{8'h0C, 8'h0B, 8'h0A};
        check_stream("hi_rel", exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
